accum_drain_ctrl: RTL and testbench

//  Downstream drain stage for the accumulator group. On a start command it reads
//  LEN consecutive addresses from all NUM_UNITS accumulator read ports in lockstep.
//  It concatenates the NUM_UNITS words of each address into one beat and streams
//  the beats out on a valid/ready interface with full backpressure, e.g. to the

---
 rtl/accum_drain_ctrl.sv | 171 +++++++++++++++++
 tb/tb_accum_drain_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_drain_ctrl.sv
// Drain stage: reads LEN addresses from all accumulator lanes in lockstep
// and streams concatenated beats out through a 2-entry skid FIFO.
module accum_drain_ctrl #(
  parameter int NUM_UNITS  = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             len,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_UNITS-1:0]            rd_en,
  output logic [NUM_UNITS*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_UNITS*DATA_WIDTH-1:0] out_data,
  output logic                            out_last
);

  localparam int BW = NUM_UNITS * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remain;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [BW-1:0]         r_d0;
  logic [BW-1:0]         r_d1;
  logic                  r_l0;
  logic                  r_l1;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_last_rd;
  logic [2:0]            w_occ;

  // Slots already committed once this cycle's pop retires; a read may
  // only be issued if its beat is guaranteed a FIFO slot on arrival.
  assign w_pop     = out_valid & out_ready;
  assign w_push    = r_inflight;
  assign w_occ     = {1'b0, r_count}
                   + {2'b00, r_inflight}
                   - {2'b00, w_pop};
  assign w_issue   = (r_state == S_RUN) && (w_occ < 3'd2);
  assign w_last_rd = (r_remain == {{ADDR_WIDTH{1'b0}}, 1'b1});

  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_en     = {NUM_UNITS{w_issue}};
  assign rd_addr   = {NUM_UNITS{r_addr}};
  assign out_valid = (r_count != 2'd0);
  assign out_data  = out_valid ? (r_rptr ? r_d1 : r_d0) : '0;
  assign out_last  = out_valid & (r_rptr ? r_l1 : r_l0);

  // Command FSM: captures the command, walks the address range,
  // then waits for the last beat to leave before pulsing done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_remain <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr   <= base_addr;
            r_remain <= len;
            r_busy   <= 1'b1;
            if (len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_addr   <= r_addr + 1'b1;
            r_remain <= r_remain - 1'b1;
            if (w_last_rd) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (w_pop && out_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Track the one-cycle read pipeline and tag the final read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_last_rd;
    end
  end

  // Two-entry FIFO storage; returning read data lands at the write pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d0   <= '0;
      r_d1   <= '0;
      r_l0   <= 1'b0;
      r_l1   <= 1'b0;
      r_wptr <= 1'b0;
    end else if (w_push) begin
      if (r_wptr) begin
        r_d1 <= rd_data;
        r_l1 <= r_inflight_last;
      end else begin
        r_d0 <= rd_data;
        r_l0 <= r_inflight_last;
      end
      r_wptr <= ~r_wptr;
    end
  end

  // FIFO read pointer and occupancy; push+pop together leaves count alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      unique case (1'b1)
        (w_push & ~w_pop): r_count <= r_count + 1'b1;
        (~w_push & w_pop): r_count <= r_count - 1'b1;
        default:           r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// Directed bench for accum_drain_ctrl with a 1-cycle read memory model
// and an independent FIFO occupancy model.
module tb_accum_drain_ctrl;

  localparam int NU = 4;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int BW = NU * DW;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     len;
  logic            busy;
  logic            done;
  logic [NU-1:0]   rd_en;
  logic [NU*AW-1:0] rd_addr;
  logic [BW-1:0]   rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [BW-1:0]   out_data;
  logic            out_last;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_n = 0;
  int done_cyc = -1;
  int busy_rise = -1;
  bit p_busy = 0;
  bit l_busy = 0;
  bit p_stall = 0;
  logic [BW-1:0] p_data;
  logic p_last;
  int m_cnt = 0;
  bit m_inf = 0;

  logic [AW-1:0] q_addr[$];
  int            q_rdcyc[$];
  logic [BW-1:0] q_beat[$];
  logic          q_last[$];
  int            q_bcyc[$];

  always #5 clk = ~clk;

  accum_drain_ctrl #(
    .NUM_UNITS (NU),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  function automatic logic [DW-1:0] word(input int i, input logic [AW-1:0] a);
    return (64'(i + 1) << 56) | 64'h0000_C0DE_0000_0000 | {55'd0, a};
  endfunction

  function automatic logic [BW-1:0] exp_beat(input logic [AW-1:0] a);
    logic [BW-1:0] b;
    for (int i = 0; i < NU; i++) b[i*DW +: DW] = word(i, a);
    return b;
  endfunction

  always @(posedge clk) begin
    if (rd_en[0]) begin
      for (int i = 0; i < NU; i++)
        rd_data[i*DW +: DW] <= word(i, rd_addr[i*AW +: AW]);
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs,
                     input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit hs;
    @(negedge clk);
    hs = out_valid & out_ready;
    chk("rd_en_lanes", rd_en, {NU{rd_en[0]}});
    chk("rd_addr_lanes", rd_addr, {NU{rd_addr[AW-1:0]}});
    chk("valid_model", out_valid, m_cnt != 0);
    if (p_stall) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, p_data);
      chk("hold_last", out_last, p_last);
    end
    if (rd_en[0]) begin
      q_addr.push_back(rd_addr[AW-1:0]);
      q_rdcyc.push_back(cyc);
    end
    if (hs) begin
      q_beat.push_back(out_data);
      q_last.push_back(out_last);
      q_bcyc.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (busy && !p_busy) busy_rise = cyc;
    p_busy  = busy;
    l_busy  = busy;
    p_stall = out_valid & ~out_ready;
    p_data  = out_data;
    p_last  = out_last;
    m_cnt   = m_cnt + int'(m_inf) - int'(hs);
    m_inf   = rd_en[0];
    chk("occupancy", (m_cnt + int'(m_inf)) <= 2, 1'b1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_rdcyc.delete();
    q_beat.delete();
    q_last.delete();
    q_bcyc.delete();
    done_n    = 0;
    done_cyc  = -1;
    busy_rise = -1;
  endtask

  task automatic cmd(input logic [AW-1:0] b, input logic [AW:0] n,
                     output int s);
    start     = 1'b1;
    base_addr = b;
    len       = n;
    s         = cyc;
    cycle();
    start     = 1'b0;
    base_addr = ~b;
    len       = 10'd7;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    int d0;
    n  = 0;
    d0 = done_n;
    while (done_n == d0 && n < maxc) begin
      cycle();
      n++;
    end
    chk("done_timeout", done_n != d0, 1'b1);
  endtask

  task automatic check_stream(input logic [AW-1:0] b, input int n);
    logic [AW-1:0] a;
    chk("n_reads", q_addr.size(), n);
    chk("n_beats", q_beat.size(), n);
    for (int k = 0; k < n && k < q_beat.size() && k < q_addr.size(); k++) begin
      a = b + AW'(k);
      chk("rd_addr", q_addr[k], a);
      chk("beat", q_beat[k], exp_beat(a));
      chk("last", q_last[k], k == n - 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, rd_en, '0);
    chk({tag, "_rd_addr"}, rd_addr, '0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_last"}, out_last, 1'b0);
  endtask

  initial begin
    int s;
    int n;
    rstn      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b1;

    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycle();

    // 1: basic stream with exact latency
    clear_log();
    cmd(9'h010, 10'd4, s);
    chk("t1_busy_first", busy, 1'b1);
    wait_done(30);
    check_stream(9'h010, 4);
    if (q_rdcyc.size() == 4) begin
      chk("t1_rd_first", q_rdcyc[0], s + 1);
      chk("t1_rd_last", q_rdcyc[3], s + 4);
    end
    if (q_bcyc.size() == 4) begin
      chk("t1_beat_first", q_bcyc[0], s + 3);
      chk("t1_beat_last", q_bcyc[3], s + 6);
    end
    chk("t1_done_cyc", done_cyc, s + 7);
    chk("t1_busy_rise", busy_rise, s + 1);
    cycle();
    chk("t1_idle", l_busy, 1'b0);
    chk("t1_done_once", done_n, 1);

    // 2: address wrap
    clear_log();
    cmd(9'h1FE, 10'd4, s);
    wait_done(30);
    check_stream(9'h1FE, 4);
    cycle();

    // 3: backpressure pattern
    clear_log();
    cmd(9'h0A0, 10'd8, s);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    wait_done(60);
    check_stream(9'h0A0, 8);
    chk("t3_done_once", done_n, 1);
    cycle();

    // 4: zero length
    clear_log();
    cmd(9'h033, 10'd0, s);
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_no_reads", q_addr.size(), 0);
    chk("t4_no_beats", q_beat.size(), 0);
    chk("t4_done_cyc", done_cyc, s + 1);
    chk("t4_busy_rise", busy_rise, s + 1);
    chk("t4_done_once", done_n, 1);
    chk("t4_idle", l_busy, 1'b0);

    // 5: start re-pulsed mid-run is ignored
    clear_log();
    cmd(9'h040, 10'd6, s);
    start     = 1'b1;
    base_addr = 9'h100;
    len       = 10'd3;
    cycle();
    cycle();
    start = 1'b0;
    wait_done(40);
    check_stream(9'h040, 6);
    chk("t5_done_once", done_n, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("t5_no_restart", q_addr.size(), 6);

    // 7: full-range length wraps through every address
    clear_log();
    cmd(9'h005, 10'd512, s);
    wait_done(600);
    check_stream(9'h005, 512);
    cycle();

    // 6: reset mid-command, then a clean short command
    clear_log();
    cmd(9'h080, 10'd10, s);
    n = 0;
    while (q_beat.size() < 3 && n < 20) begin
      cycle();
      n++;
    end
    chk("t6_three_beats", q_beat.size(), 3);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_rst");
    m_cnt   = 0;
    m_inf   = 0;
    p_stall = 1'b0;
    p_busy  = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_log();
    cycle();
    chk("t6_no_done_after_rst", done_n, 0);
    cmd(9'h020, 10'd2, s);
    wait_done(30);
    for (int i = 0; i < 4; i++) cycle();
    check_stream(9'h020, 2);
    chk("t6_done_once", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
